// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: ctrl+data over valid/ready, optional 2-entry skid buffer.
// Latency: 1 cycle from accept to out_*; 1 entry/cycle sustained while out_ready=1.
// Backpressure: SKID=1 registers in_ready (low only when skid slot full); SKID=0 in_ready = !out_valid || out_ready.
module pipe_stage_elastic #(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 16,
  parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
  parameter bit                 SKID     = 1'b1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // EMPTY: nothing held. ONE: main register valid. FULL: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // What the main register loads at the next edge.
  typedef enum logic [1:0] {
    M_HOLD    = 2'd0,
    M_LOAD_IN = 2'd1,
    M_LOAD_S  = 2'd2,
    M_CLEAR   = 2'd3
  } m_sel_t;

  // What the skid register loads at the next edge.
  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_LOAD_IN = 2'd1,
    S_CLEAR   = 2'd2
  } s_sel_t;

  state_t            r_state;
  state_t            w_state_nxt;
  m_sel_t            w_m_sel;
  s_sel_t            w_s_sel;

  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic              r_in_rdy;
  logic [CNT_W-1:0]  r_stall;

  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_deliver;

  // The main register is the head entry; it is valid whenever anything is held.
  assign w_out_valid = (r_state != ST_EMPTY);

  // With the skid buffer, in_ready comes straight from a flop so the upstream
  // ready path is cut; without it, ready looks through to out_ready.
  assign w_in_ready  = SKID ? r_in_rdy : (!w_out_valid || out_ready);

  assign w_accept    = in_valid && w_in_ready;
  assign w_deliver   = w_out_valid && out_ready;

  // Next-state and register load selection; flush overrides every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_m_sel     = M_HOLD;
    w_s_sel     = S_HOLD;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_m_sel     = M_CLEAR;
      w_s_sel     = S_CLEAR;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_m_sel     = M_LOAD_IN;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_m_sel     = M_LOAD_IN;
          end else if (w_accept) begin
            // Only reachable with the skid buffer: the head is stuck, park the
            // new entry behind it.
            if (SKID) begin
              w_state_nxt = ST_FULL;
              w_s_sel     = S_LOAD_IN;
            end
          end else if (w_deliver) begin
            w_state_nxt = ST_EMPTY;
            w_m_sel     = M_CLEAR;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a delivery can move things.
          if (w_deliver) begin
            w_state_nxt = ST_ONE;
            w_m_sel     = M_LOAD_S;
            w_s_sel     = S_CLEAR;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_m_sel     = M_CLEAR;
          w_s_sel     = S_CLEAR;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered in_ready for the skid configuration: low only while the skid slot is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_rdy <= 1'b1;
    end else begin
      r_in_rdy <= (w_state_nxt != ST_FULL);
    end
  end

  // Main (head) register; cleared to a bubble whenever it empties so out_* never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_ctrl <= '0;
      r_m_data <= NOP_DATA;
    end else begin
      case (w_m_sel)
        M_LOAD_IN: begin
          r_m_ctrl <= in_ctrl;
          r_m_data <= in_data;
        end
        M_LOAD_S: begin
          r_m_ctrl <= r_s_ctrl;
          r_m_data <= r_s_data;
        end
        M_CLEAR: begin
          r_m_ctrl <= '0;
          r_m_data <= NOP_DATA;
        end
        default: begin
          r_m_ctrl <= r_m_ctrl;
          r_m_data <= r_m_data;
        end
      endcase
    end
  end

  // Skid register; holds the entry that arrived while the head was back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ctrl <= '0;
      r_s_data <= NOP_DATA;
    end else begin
      case (w_s_sel)
        S_LOAD_IN: begin
          r_s_ctrl <= in_ctrl;
          r_s_data <= in_data;
        end
        S_CLEAR: begin
          r_s_ctrl <= '0;
          r_s_data <= NOP_DATA;
        end
        default: begin
          r_s_ctrl <= r_s_ctrl;
          r_s_data <= r_s_data;
        end
      endcase
    end
  end

  // Saturating count of cycles the head entry was refused; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_ctrl     = r_m_ctrl;
  assign out_data     = r_m_data;
  assign occupancy    = (r_state == ST_FULL) ? 2'd2 :
                        (r_state == ST_ONE)  ? 2'd1 : 2'd0;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid (index 0) and no-skid (index 1) instances, queue-based reference model.
// Outputs are compared at the falling edge; the model advances at the rising edge.
// Each instance has its own upstream that holds an offer until it is taken.
module tb_pipe_stage_elastic;
  localparam int          DW  = 64;
  localparam int          CW  = 16;
  localparam int          NW  = 4;
  localparam logic [63:0] NOP = 64'hDEAD_BEEF_0BAD_F00D;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [DW-1:0] in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    occupancy [2];
  logic [NW-1:0] stall     [2];

  int total = 0;
  int bad   = 0;

  // Reference model: held entries in arrival order, {ctrl,data}.
  logic [79:0] mq   [2][$];
  int          mst  [2];
  bit          pend [2];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .NOP_DATA(NOP), .SKID(1'b1), .CNT_W(NW)) u_skid (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0]), .stall_cycles(stall[0])
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .NOP_DATA(NOP), .SKID(1'b0), .CNT_W(NW)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1]), .stall_cycles(stall[1])
  );

  // Skid instance takes a new entry while fewer than two are held; the
  // single-entry instance only when empty or its head leaves this cycle.
  function automatic bit exp_rdy(input int d);
    if (d == 0) return (mq[d].size() < 2);
    return (mq[d].size() == 0) || out_ready[d];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [79:0] h;
      h = (mq[d].size() > 0) ? mq[d][0] : {16'h0, NOP};
      chk($sformatf("d%0d out_valid", d), 64'(out_valid[d]), 64'(mq[d].size() > 0));
      chk($sformatf("d%0d out_ctrl", d),  64'(out_ctrl[d]),  64'(h[79:64]));
      chk($sformatf("d%0d out_data", d),  out_data[d],       h[63:0]);
      chk($sformatf("d%0d in_ready", d),  64'(in_ready[d]),  64'(exp_rdy(d)));
      chk($sformatf("d%0d occupancy", d), 64'(occupancy[d]), 64'(mq[d].size()));
      chk($sformatf("d%0d stall", d),     64'(stall[d]),     64'(mst[d]));
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit acc, del;
      if (rst) begin
        mq[d].delete(); mst[d] = 0; pend[d] = 1'b0;
      end else begin
        acc = in_valid[d] && exp_rdy(d);
        del = (mq[d].size() > 0) && out_ready[d];
        pend[d] = in_valid[d] && !acc;
        if ((mq[d].size() > 0) && !out_ready[d] && (mst[d] < SAT)) mst[d]++;
        if (flush[d]) begin
          mq[d].delete();
        end else begin
          if (del) void'(mq[d].pop_front());
          if (acc) mq[d].push_back({in_ctrl[d], in_data[d]});
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [63:0] dat, input bit ordy, input bit fl);
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = v;
      in_data[d]   = dat;
      in_ctrl[d]   = dat[15:0] ^ 16'h5A00;
      out_ready[d] = ordy;
      flush[d]     = fl;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin mq[d].delete(); mst[d] = 0; pend[d] = 1'b0; end
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #1;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) cycle();

    // Back-to-back stream 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin drive(1'b1, 64'(i), 1'b1, 1'b0); cycle(); end
    drive(1'b0, 64'h0, 1'b1, 1'b0); cycle(); cycle();

    // Backpressure: 0xA then 0xB with out_ready low, then drain.
    drive(1'b1, 64'hA, 1'b0, 1'b0); cycle();
    drive(1'b1, 64'hB, 1'b0, 1'b0); cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0); cycle();
    chk("bp skid occupancy", 64'(occupancy[0]), 64'd2);
    chk("bp skid in_ready",  64'(in_ready[0]),  64'd0);
    chk("bp skid head",      out_data[0],       64'hA);
    chk("bp skid stall",     64'(stall[0]),     64'd2);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Flush while full, with an offer of 0xC in the flush cycle.
    drive(1'b1, 64'hA, 1'b0, 1'b0); cycle();
    drive(1'b1, 64'hB, 1'b0, 1'b0); cycle();
    drive(1'b1, 64'hC, 1'b0, 1'b1); cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0); cycle();
    chk("flush occupancy", 64'(occupancy[0]), 64'd0);
    chk("flush in_ready",  64'(in_ready[0]),  64'd1);
    chk("flush out_data",  out_data[0],       NOP);
    drive(1'b0, 64'h0, 1'b1, 1'b0); cycle(); cycle();

    // Counter saturation with one entry stuck, survives flush, cleared by reset.
    do_reset();
    drive(1'b1, 64'h77, 1'b0, 1'b0); cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat skid",   64'(stall[0]), 64'd15);
    chk("sat noskid", 64'(stall[1]), 64'd15);
    drive(1'b0, 64'h0, 1'b0, 1'b1); cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0); cycle();
    chk("sat after flush", 64'(stall[0]), 64'd15);
    do_reset();
    chk("stall after rst", 64'(stall[0]), 64'd0);

    // Randomised traffic; an offer is held until it is accepted.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!pend[d]) begin
          in_valid[d] = ($urandom_range(0, 2) != 0);
          in_data[d]  = {$urandom, $urandom};
          in_ctrl[d]  = 16'($urandom);
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
        flush[d]     = ($urandom_range(0, 31) == 0);
      end
      cycle();
    end

    drive(1'b0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline stage register. It is the successor to the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Carries an opaque data bus plus a control bus over a valid/ready handshake.
- Optional 2-entry skid buffer, so in_ready is registered and timing paths between stages are cut.
- Synchronous flush that injects a bubble (control zeroed, data = NOP_DATA).
- Stall-cycle performance counter.
- Placed between any two pipeline stages.

Parameters:
DATA_W, 64, width of the opaque payload (PC, instr, operands, imm).
CTRL_W, 16, width of the control field (RegWrite, MemWrite, ...); zeroed whenever the stage holds a bubble.
NOP_DATA, {DATA_W{1'b0}}, payload value presented when the stage holds a bubble.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the stall_cycles counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream offers an entry.
in_ready  out  1  stage can accept an entry this cycle.
in_ctrl  in  CTRL_W  upstream control field.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage presents an entry.
out_ready  in  1  downstream accepts the entry this cycle.
out_ctrl  out  CTRL_W  control field of the head entry; 0 when !out_valid.
out_data  out  DATA_W  payload of the head entry; NOP_DATA when !out_valid.
occupancy  out  2  number of valid entries held (0..2).
stall_cycles  out  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Reset (async):
  - out_valid=0, out_ctrl=0, out_data=NOP_DATA.
  - Skid entry invalid, ctrl 0, data NOP_DATA.
  - in_ready=1, occupancy=0, stall_cycles=0.
- Accept: in_valid&&in_ready at a clk edge. Deliver: out_valid&&out_ready at a clk edge.
- Latency: an accepted entry appears on out_* the next cycle. Throughput: 1 entry/cycle sustained when out_ready=1.
- Entries leave in order; none are dropped or duplicated except by flush.
- While out_valid&&!out_ready, out_ctrl and out_data hold stable.
- When the head entry drains and nothing replaces it, out_ctrl returns to 0 and out_data returns to NOP_DATA (explicit bubble).
- SKID=1 state machine (M = main register, S = skid register); in_ready = !S_valid, registered:
  - EMPTY:
    - accept -> ONE (M<=in).
  - ONE:
    - accept and deliver -> ONE (M<=in).
    - accept only -> FULL (S<=in, in_ready drops next cycle).
    - deliver only -> EMPTY.
    - neither -> ONE.
  - FULL (in_ready=0):
    - deliver -> ONE (M<=S, S cleared to bubble).
    - else -> FULL.
- SKID=0:
  - Only EMPTY and ONE exist.
  - in_ready = !out_valid || out_ready (combinational); FULL is unreachable.
  - occupancy is at most 1.
- Flush:
  - Synchronous; highest priority after rst.
  - At the edge: M and S are invalidated and cleared to bubble; any accept in that cycle is discarded; state -> EMPTY.
  - out_* during the flush cycle still reflect the pre-flush state.
  - in_ready is 1 in the cycle after the flush.
  - stall_cycles is not affected.
- stall_cycles: +1 at each edge where out_valid&&!out_ready; saturates at 2^CNT_W-1; cleared only by rst.
- occupancy = M_valid + S_valid.
- Protocol: upstream holds in_ctrl/in_data stable while in_valid&&!in_ready. Withdrawing in_valid without an accept is legal and leaves the stage unchanged.

Test Plan:
- Reset release, no traffic -> out_valid=0, out_ctrl=0, out_data=NOP_DATA, in_ready=1, occupancy=0 for 5 cycles.
- Stream: in_data=1..8 on consecutive cycles, out_ready=1 -> out_data=1..8 one cycle later, back-to-back; occupancy stays 1; stall_cycles=0.
- Backpressure (SKID=1): feed 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held, stall_cycles=2 after 2 cycles. Raise out_ready -> 0xA then 0xB delivered; in_ready returns to 1 one cycle after the first deliver.
- Flush while FULL, with in_valid=1 and in_data=0xC in the same cycle -> next cycle out_valid=0, out_ctrl=0, out_data=NOP_DATA, occupancy=0, in_ready=1; 0xC never appears.
- Counter saturation (CNT_W=4, out_ready=0 for 20 cycles with one entry held) -> stall_cycles stops at 15. Flush -> stays 15. rst -> 0.
- SKID=0: out_ready=0 with one entry held -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, and a new entry is accepted on the same edge the old one is delivered.
